// File: rtl/div_controller_datapath.sv
// ---------------------------------------------------------------------------
// div_controller_datapath
//
// Sequential 8-bit unsigned divider using repeated subtraction. A control FSM
// steers a small datapath: A holds the dividend and becomes the remainder, B
// holds the divisor, and Q counts successful subtractions. Dividend and
// divisor arrive one after the other on the shared data_in bus, on the two
// cycles that follow the start request.
//
// Optional feature macro: DIV_ERR_FLAG_EN
//   When it is defined, the div_err port and its flag register exist.
//   Without it, divide-by-zero still ends with quotient 8'hFF and
//   remainder = dividend. There is simply no flag output.
//
// Ports:
//   clk        in   1  clock; all state changes on the rising edge
//   rst        in   1  synchronous active-high reset (wins over everything)
//   start      in   1  request, sampled in IDLE and DONE only
//   data_in    in   8  dividend (LOAD_A cycle), divisor (LOAD_B cycle)
//   done       out  1  high while the FSM is in DONE
//   quotient   out  8  Q register (valid while done = 1)
//   remainder  out  8  A register (valid while done = 1)
//   div_err    out  1  divide-by-zero flag (DIV_ERR_FLAG_EN builds only)
// ---------------------------------------------------------------------------
module div_controller_datapath (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic       done,
   output logic [7:0] quotient,
   output logic [7:0] remainder
`ifdef DIV_ERR_FLAG_EN
   ,
   output logic       div_err
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      SUB    = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t     state_reg;
   state_t     state_next;

   logic [7:0] a_reg;
   logic [7:0] b_reg;
   logic [7:0] q_reg;

   // Datapath controls decoded by the FSM.
   logic       load_a;
   logic       load_b;
   logic       sub_en;
   logic       div_zero;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      load_a     = 1'b0;
      load_b     = 1'b0;
      sub_en     = 1'b0;
      div_zero   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = LOAD_A;
            end
         end
         LOAD_A: begin
            load_a     = 1'b1;
            state_next = LOAD_B;
         end
         LOAD_B: begin
            load_b     = 1'b1;
            state_next = SUB;
         end
         SUB: begin
            // The zero test must come first. Otherwise A >= 0 would hold
            // forever and the loop would never end.
            if (b_reg == 8'd0) begin
               div_zero   = 1'b1;
               state_next = DONE;
            end else if (a_reg >= b_reg) begin
               sub_en     = 1'b1;
            end else begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Leaving DONE needs start to drop first. This prevents an
            // automatic restart while start is still held.
            if (!start) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg <= 8'd0;
         b_reg <= 8'd0;
         q_reg <= 8'd0;
      end else begin
         if (load_a) begin
            a_reg <= data_in;
         end
         if (load_b) begin
            b_reg <= data_in;
            q_reg <= 8'd0;
         end
         if (sub_en) begin
            // The compare guarantees that A >= B, so this cannot underflow.
            a_reg <= a_reg - b_reg;
            q_reg <= q_reg + 8'd1;
         end
         if (div_zero) begin
            // Divide-by-zero result: an all-ones quotient. A keeps the dividend.
            q_reg <= 8'hFF;
         end
      end
   end

`ifdef DIV_ERR_FLAG_EN
   logic err_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (div_zero) begin
         err_reg <= 1'b1;
      end else if ((state_reg == DONE) && !start) begin
         err_reg <= 1'b0;
      end
   end

   assign div_err = err_reg;
`endif

   // done is decoded only from the state register. This gives a registered
   // output with no path from any input.
   assign done      = (state_reg == DONE);
   assign quotient  = q_reg;
   assign remainder = a_reg;

endmodule

// File: tb/tb_div_controller_datapath.sv
// ---------------------------------------------------------------------------
// tb_div_controller_datapath
//
// Self-checking bench for div_controller_datapath. It uses a behavioural model
// that predicts when done rises and what the result is, using plain division
// and modulo. A compare process checks the DUT against that model every cycle.
// Directed divisions with literal expected results pin the model, and
// randomized divisions toggle start while the divider is busy.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_div_controller_datapath;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] data_in;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
`ifdef DIV_ERR_FLAG_EN
   logic       div_err;
`endif

   div_controller_datapath dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef DIV_ERR_FLAG_EN
      ,
      .div_err   (div_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model. The phase tracks the protocol:
   //   0 idle, 1 dividend, 2 divisor, 3 busy countdown, 4 done.
   // The busy time is simply the true quotient (0 for divide-by-zero).
   // ------------------------------------------------------------------
   int         m_ph   = 0;
   bit         m_done = 1'b0;
   logic [7:0] m_a    = 8'd0;
   logic [7:0] m_b    = 8'd0;
   int         m_cnt  = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_ph   <= 0;
         m_done <= 1'b0;
      end else begin
         case (m_ph)
            0: if (start) m_ph <= 1;
            1: begin m_a <= data_in; m_ph <= 2; end
            2: begin
               m_b   <= data_in;
               m_cnt <= (data_in == 8'd0) ? 0 : int'(m_a / data_in);
               m_ph  <= 3;
            end
            3: begin
               if (m_cnt == 0) begin
                  m_ph   <= 4;
                  m_done <= 1'b1;
               end else begin
                  m_cnt <= m_cnt - 1;
               end
            end
            4: if (!start) begin m_ph <= 0; m_done <= 1'b0; end
            default: m_ph <= 0;
         endcase
      end
   end

   // Compare process: done is checked on every cycle. The result is checked
   // whenever the model says it is valid.
   always @(negedge clk) begin
      if (check_en) begin
         chk("done", int'(done), int'(m_done));
         if (m_done) begin
            chk("quotient", int'(quotient),
                (m_b == 8'd0) ? 255 : int'(m_a / m_b));
            chk("remainder", int'(remainder),
                (m_b == 8'd0) ? int'(m_a) : int'(m_a % m_b));
         end
`ifdef DIV_ERR_FLAG_EN
         chk("div_err", int'(div_err), int'(m_done && (m_b == 8'd0)));
`endif
      end
   end

   // ------------------------------------------------------------------
   // One division. edges = posedges from the start-sampling edge E0 up to
   // the edge that raises done; this is expected to be 3 + quotient.
   // If pin is set, literal expectations are also checked.
   // ------------------------------------------------------------------
   task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                          input bit toggle, input bit pin,
                          input int pq, input int pr, input int pe);
      int  edges;
      int  exp_edges;
      bit  seen;
      @(negedge clk);
      start   = 1'b1;
      data_in = 8'($urandom);
      @(posedge clk);                       // E0
      @(negedge clk);
      data_in = a;
      if (toggle) start = 1'($urandom_range(0, 1));
      @(posedge clk);                       // E0+1: dividend
      @(negedge clk);
      data_in = b;
      @(posedge clk);                       // E0+2: divisor
      edges = 2;
      seen  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         data_in = 8'($urandom);
         if (toggle) start = 1'($urandom_range(0, 1));
         @(posedge clk);
         edges++;
      end
      exp_edges = (b == 8'd0) ? 3 : 3 + int'(a / b);
      if (!seen) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("latency", edges, exp_edges);
         if (pin) begin
            chk("pin_quotient", int'(quotient), pq);
            chk("pin_remainder", int'(remainder), pr);
            chk("pin_latency", edges, pe);
`ifdef DIV_ERR_FLAG_EN
            chk("pin_div_err", int'(div_err), int'(b == 8'd0));
`endif
         end
      end
      // Hold start: the compare process verifies that done stays high.
      start = 1'b1;
      repeat (3) @(negedge clk);
      // Drop start for one cycle so that DONE returns to IDLE.
      start = 1'b0;
      @(negedge clk);
      chk("idle_after_drop", int'(done), 0);
      $display("div %0d / %0d -> q=%0d r=%0d edges=%0d", a, b,
               (b == 8'd0) ? 255 : int'(a / b),
               (b == 8'd0) ? int'(a) : int'(a % b), edges);
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      rst     = 1'b1;
      start   = 1'b0;
      data_in = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_done", int'(done), 0);
      chk("reset_quotient", int'(quotient), 0);
      chk("reset_remainder", int'(remainder), 0);
`ifdef DIV_ERR_FLAG_EN
      chk("reset_div_err", int'(div_err), 0);
`endif
      rst      = 1'b0;
      check_en = 1'b1;

      run_div(8'd100, 8'd23,  1'b0, 1'b1, 4,   8,  7);
      run_div(8'd23,  8'd100, 1'b0, 1'b1, 0,   23, 3);
      run_div(8'd255, 8'd1,   1'b0, 1'b1, 255, 0,  258);
      run_div(8'd200, 8'd200, 1'b0, 1'b1, 1,   0,  4);
      run_div(8'd7,   8'd0,   1'b0, 1'b1, 255, 7,  3);

      // Reset during the SUB phase of 100 / 3.
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_in = 8'd100;
      @(posedge clk);
      @(negedge clk);
      data_in = 8'd3;
      start   = 1'b0;
      @(posedge clk);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_done", int'(done), 0);
      chk("midreset_quotient", int'(quotient), 0);
      chk("midreset_remainder", int'(remainder), 0);
      rst = 1'b0;
      $display("reset asserted during 100 / 3");

      run_div(8'd50, 8'd7, 1'b0, 1'b1, 7, 1, 10);
      run_div(8'd9,  8'd4, 1'b1, 1'b1, 2, 1, 5);

      for (int k = 0; k < 20; k++) begin
         ra = 8'($urandom);
         rb = (k % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 40));
         run_div(ra, rb, 1'b1, 1'b0, 0, 0, 0);
      end

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
